// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared instruction, register and condition encodings for the execute stage
package execute_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // Register id meaning "no destination".
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_XOR = 4'h3
   } alu_fn_e;

   typedef enum logic [3:0] {
      C_YES = 4'h0,
      C_LE  = 4'h1,
      C_L   = 4'h2,
      C_E   = 4'h3,
      C_NE  = 4'h4,
      C_GE  = 4'h5,
      C_G   = 4'h6
   } cond_e;

   // Branch / conditional-move predicate over a condition-code snapshot.
   function automatic logic eval_cond(input logic [3:0] fn, input logic zf, input logic sf,
                                      input logic of);
      logic r;
      case (fn)
         C_YES:   r = 1'b1;
         C_LE:    r = (sf ^ of) | zf;
         C_L:     r = sf ^ of;
         C_E:     r = zf;
         C_NE:    r = !zf;
         C_GE:    r = !(sf ^ of);
         C_G:     r = !(sf ^ of) & !zf;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/execute_pipe_alu.sv
// rtl/execute_pipe_alu.sv - combinational execute datapath producing valE and result flags
module alu
   import execute_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int WORD_BYTES = WIDTH / 8
) (
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);
   localparam int MSB = WIDTH - 1;

   // Select the operation by icode; overflow is only meaningful for add/sub.
   always_comb begin
      result = '0;
      of     = 1'b0;
      case (icode)
         I_OPQ: begin
            case (ifun)
               ALU_ADD: begin
                  result = b + a;
                  of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
               end
               ALU_SUB: begin
                  result = b - a;
                  of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
               end
               ALU_AND: result = b & a;
               ALU_XOR: result = b ^ a;
               default: result = '0;
            endcase
         end
         I_RRMOVQ:          result = a;
         I_IRMOVQ:          result = c;
         I_RMMOVQ, I_MRMOVQ: result = b + c;
         I_CALL, I_PUSHQ:   result = b - STEP;
         I_RET, I_POPQ:     result = b + STEP;
         default:           result = '0;
      endcase
      zf = (result == '0);
      sf = result[MSB];
   end

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - execute stage with condition codes, branch predicate and E-to-M register
module execute_pipe
   import execute_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int WORD_BYTES = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             bubble,
   input  logic             exc_block,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic [WIDTH-1:0] valC,
   input  logic [3:0]       dstE,
   input  logic [3:0]       dstM,
   output logic             out_valid,
   output logic [3:0]       out_icode,
   output logic [WIDTH-1:0] out_valE,
   output logic [WIDTH-1:0] out_valA,
   output logic [3:0]       out_dstE,
   output logic [3:0]       out_dstM,
   output logic             out_cnd,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic [WIDTH-1:0] fwd_valE,
   output logic [3:0]       fwd_dstE
);

   logic [WIDTH-1:0] w_alu_result;
   logic             w_alu_zf;
   logic             w_alu_sf;
   logic             w_alu_of;
   logic             w_cnd;
   logic [3:0]       w_dstE;
   logic             w_cc_load;
   logic             r_zf;
   logic             r_sf;
   logic             r_of;
   logic             r_valid;
   logic [3:0]       r_icode;
   logic [WIDTH-1:0] r_valE;
   logic [WIDTH-1:0] r_valA;
   logic [3:0]       r_dstE;
   logic [3:0]       r_dstM;
   logic             r_cnd;

   alu #(
      .WIDTH      (WIDTH),
      .WORD_BYTES (WORD_BYTES)
   ) u_alu (
      .icode  (icode),
      .ifun   (ifun),
      .a      (valA),
      .b      (valB),
      .c      (valC),
      .result (w_alu_result),
      .zf     (w_alu_zf),
      .sf     (w_alu_sf),
      .of     (w_alu_of)
   );

   // Condition uses the CC as it stands before this instruction's own update.
   assign w_cnd     = eval_cond(ifun, r_zf, r_sf, r_of);
   // A cmov whose condition fails writes nothing.
   assign w_dstE    = ((icode == I_RRMOVQ) && !w_cnd) ? RNONE : dstE;
   assign w_cc_load = in_valid && (icode == I_OPQ) && (ifun <= 4'd3)
                      && !stall && !bubble && !exc_block;

   assign fwd_valE  = w_alu_result;
   assign fwd_dstE  = (!in_valid || bubble) ? RNONE : w_dstE;

   // Condition-code register: reset to "zero result", load only on committed OPq.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_zf <= 1'b1;
         r_sf <= 1'b0;
         r_of <= 1'b0;
      end else if (w_cc_load) begin
         r_zf <= w_alu_zf;
         r_sf <= w_alu_sf;
         r_of <= w_alu_of;
      end
   end

   // E-to-M register: reset and bubble load a NOP, stall holds, otherwise capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_icode <= I_NOP;
         r_valE  <= '0;
         r_valA  <= '0;
         r_dstE  <= RNONE;
         r_dstM  <= RNONE;
         r_cnd   <= 1'b0;
      end else if (stall) begin
         r_valid <= r_valid;
      end else if (bubble || !in_valid) begin
         r_valid <= 1'b0;
         r_icode <= I_NOP;
         r_valE  <= '0;
         r_valA  <= '0;
         r_dstE  <= RNONE;
         r_dstM  <= RNONE;
         r_cnd   <= 1'b0;
      end else begin
         r_valid <= 1'b1;
         r_icode <= icode;
         r_valE  <= w_alu_result;
         r_valA  <= valA;
         r_dstE  <= w_dstE;
         r_dstM  <= dstM;
         r_cnd   <= w_cnd;
      end
   end

   assign zf        = r_zf;
   assign sf        = r_sf;
   assign of        = r_of;
   assign out_valid = r_valid;
   assign out_icode = r_icode;
   assign out_valE  = r_valE;
   assign out_valA  = r_valA;
   assign out_dstE  = r_dstE;
   assign out_dstM  = r_dstM;
   assign out_cnd   = r_cnd;

endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - directed self-checking bench for execute_pipe at WIDTH 64 and 32
module tb_execute_pipe;
   import execute_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, stall, bubble, exc_block;
   logic [3:0]  icode, ifun, dstE, dstM;
   logic [63:0] a64, b64, c64;
   logic [31:0] a32, b32, c32;

   logic        v64, cnd64, zf64, sf64, of64;
   logic [3:0]  ic64, de64, dm64, fd64;
   logic [63:0] ve64, va64, fv64;
   logic        v32, cnd32, zf32, sf32, of32;
   logic [3:0]  ic32, de32, dm32, fd32;
   logic [31:0] ve32, va32, fv32;

   int checks = 0;
   int errors = 0;

   execute_pipe #(.WIDTH(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .bubble(bubble),
      .exc_block(exc_block), .icode(icode), .ifun(ifun), .valA(a64), .valB(b64), .valC(c64),
      .dstE(dstE), .dstM(dstM), .out_valid(v64), .out_icode(ic64), .out_valE(ve64),
      .out_valA(va64), .out_dstE(de64), .out_dstM(dm64), .out_cnd(cnd64), .zf(zf64),
      .sf(sf64), .of(of64), .fwd_valE(fv64), .fwd_dstE(fd64)
   );

   execute_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .bubble(bubble),
      .exc_block(exc_block), .icode(icode), .ifun(ifun), .valA(a32), .valB(b32), .valC(c32),
      .dstE(dstE), .dstM(dstM), .out_valid(v32), .out_icode(ic32), .out_valE(ve32),
      .out_valA(va32), .out_dstE(de32), .out_dstM(dm32), .out_cnd(cnd32), .zf(zf32),
      .sf(sf32), .of(of32), .fwd_valE(fv32), .fwd_dstE(fd32)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
      icode = ic; ifun = fn; a64 = a; b64 = b; c64 = c;
      a32 = a[31:0]; b32 = b[31:0]; c32 = c[31:0];
      dstE = de; dstM = RNONE;
      in_valid = 1'b1; stall = 1'b0; bubble = 1'b0; exc_block = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      issue(I_OPQ, 4'h0, 64'd1, 64'd1, 64'd0, 4'd2);
      stall = 1'b1;
      step();
      checks++; if (v64 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", v64); end
      checks++; if (ic64 !== I_NOP) begin errors++; $display("FAIL rst_icode got %h want 1", ic64); end
      checks++; if (de64 !== RNONE) begin errors++; $display("FAIL rst_dstE got %h want f", de64); end
      checks++; if ({zf64, sf64, of64} !== 3'b100) begin errors++; $display("FAIL rst_cc got %b want 100", {zf64, sf64, of64}); end
      checks++; if (ve64 !== 64'd0) begin errors++; $display("FAIL rst_valE got %h want 0", ve64); end
      rst_n = 1'b1;
      stall = 1'b0;
   endtask

   task automatic test_sub();
      issue(I_OPQ, 4'h1, 64'd91, 64'd100, 64'd0, 4'd2);
      #1;
      checks++; if (fv64 !== 64'd9) begin errors++; $display("FAIL sub_fwd_valE got %h want 9", fv64); end
      checks++; if (fd64 !== 4'd2) begin errors++; $display("FAIL sub_fwd_dstE got %h want 2", fd64); end
      step();
      checks++; if (ve64 !== 64'd9) begin errors++; $display("FAIL sub_valE got %h want 9", ve64); end
      checks++; if ({v64, de64, dm64} !== {1'b1, 4'd2, RNONE}) begin errors++; $display("FAIL sub_ctl got %b/%h/%h want 1/2/f", v64, de64, dm64); end
      checks++; if (va64 !== 64'd91) begin errors++; $display("FAIL sub_valA got %h want 5b", va64); end
      checks++; if ({zf64, sf64, of64} !== 3'b000) begin errors++; $display("FAIL sub_cc got %b want 000", {zf64, sf64, of64}); end
   endtask

   task automatic test_add_ovf();
      issue(I_OPQ, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd3);
      step();
      checks++; if (ve64 !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_ovf_valE got %h want 8000000000000000", ve64); end
      checks++; if ({zf64, sf64, of64} !== 3'b011) begin errors++; $display("FAIL add_ovf_cc got %b want 011", {zf64, sf64, of64}); end
   endtask

   task automatic test_cond();
      issue(I_OPQ, 4'h1, 64'd3, 64'd3, 64'd0, 4'd1);
      step();
      checks++; if ({zf64, sf64, of64} !== 3'b100) begin errors++; $display("FAIL eq_cc got %b want 100", {zf64, sf64, of64}); end
      issue(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
      step();
      checks++; if (cnd64 !== 1'b1) begin errors++; $display("FAIL je_cnd got %b want 1", cnd64); end
      issue(I_JXX, C_NE, 64'd0, 64'd0, 64'd0, RNONE);
      step();
      checks++; if (cnd64 !== 1'b0) begin errors++; $display("FAIL jne_cnd got %b want 0", cnd64); end
      issue(I_JXX, C_LE, 64'd0, 64'd0, 64'd0, RNONE);
      step();
      checks++; if (cnd64 !== 1'b1) begin errors++; $display("FAIL jle_cnd got %b want 1", cnd64); end
   endtask

   task automatic test_cmov();
      issue(I_OPQ, 4'h1, 64'd91, 64'd100, 64'd0, 4'd2);
      step();
      issue(I_RRMOVQ, C_L, 64'd9, 64'd0, 64'd0, 4'd3);
      #1;
      checks++; if (fd64 !== RNONE) begin errors++; $display("FAIL cmovl_fwd_dstE got %h want f", fd64); end
      step();
      checks++; if (ve64 !== 64'd9) begin errors++; $display("FAIL cmovl_valE got %h want 9", ve64); end
      checks++; if ({cnd64, de64} !== {1'b0, RNONE}) begin errors++; $display("FAIL cmovl_ctl got %b/%h want 0/f", cnd64, de64); end
      issue(I_RRMOVQ, C_GE, 64'd9, 64'd0, 64'd0, 4'd3);
      step();
      checks++; if ({cnd64, de64} !== {1'b1, 4'd3}) begin errors++; $display("FAIL cmovge_ctl got %b/%h want 1/3", cnd64, de64); end
   endtask

   task automatic test_stall_bubble_exc();
      issue(I_OPQ, 4'h0, 64'd5, 64'd6, 64'd0, 4'd4);
      step();
      checks++; if (ve64 !== 64'd11) begin errors++; $display("FAIL add_valE got %h want b", ve64); end
      issue(I_OPQ, 4'h0, 64'd0, 64'd0, 64'd0, 4'd5);
      stall = 1'b1;
      step();
      checks++; if ({v64, ve64, de64, zf64} !== {1'b1, 64'd11, 4'd4, 1'b0}) begin errors++; $display("FAIL stall1 got %b/%h/%h/%b want 1/b/4/0", v64, ve64, de64, zf64); end
      bubble = 1'b1;
      step();
      checks++; if ({v64, ve64, de64, zf64} !== {1'b1, 64'd11, 4'd4, 1'b0}) begin errors++; $display("FAIL stall2 got %b/%h/%h/%b want 1/b/4/0", v64, ve64, de64, zf64); end
      stall = 1'b0;
      #1;
      checks++; if (fd64 !== RNONE) begin errors++; $display("FAIL bubble_fwd_dstE got %h want f", fd64); end
      step();
      checks++; if ({v64, ic64, de64, ve64, cnd64} !== {1'b0, I_NOP, RNONE, 64'd0, 1'b0}) begin errors++; $display("FAIL bubble_nop got %b/%h/%h/%h/%b want 0/1/f/0/0", v64, ic64, de64, ve64, cnd64); end
      checks++; if (zf64 !== 1'b0) begin errors++; $display("FAIL bubble_cc got %b want 0", zf64); end
      issue(I_OPQ, 4'h0, 64'd0, 64'd0, 64'd0, 4'd5);
      exc_block = 1'b1;
      step();
      checks++; if ({v64, ve64, de64} !== {1'b1, 64'd0, 4'd5}) begin errors++; $display("FAIL exc_out got %b/%h/%h want 1/0/5", v64, ve64, de64); end
      checks++; if (zf64 !== 1'b0) begin errors++; $display("FAIL exc_cc got %b want 0", zf64); end
      in_valid = 1'b0;
      exc_block = 1'b0;
      #1;
      checks++; if (fd64 !== RNONE) begin errors++; $display("FAIL idle_fwd_dstE got %h want f", fd64); end
      step();
      checks++; if (v64 !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", v64); end
   endtask

   task automatic test_misc_ops();
      issue(I_IRMOVQ, 4'h0, 64'd0, 64'd0, 64'h1234, 4'd1);
      step();
      checks++; if (ve64 !== 64'h1234) begin errors++; $display("FAIL irmovq got %h want 1234", ve64); end
      issue(I_MRMOVQ, 4'h0, 64'd0, 64'h10, 64'h8, RNONE);
      step();
      checks++; if (ve64 !== 64'h18) begin errors++; $display("FAIL mrmovq got %h want 18", ve64); end
      issue(I_CALL, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4);
      step();
      checks++; if (ve64 !== 64'hF8) begin errors++; $display("FAIL call got %h want f8", ve64); end
      issue(I_RET, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4);
      step();
      checks++; if (ve64 !== 64'h108) begin errors++; $display("FAIL ret got %h want 108", ve64); end
      issue(I_OPQ, 4'h2, 64'h3C, 64'hF0, 64'd0, 4'd1);
      step();
      checks++; if (ve64 !== 64'h30) begin errors++; $display("FAIL andq got %h want 30", ve64); end
      issue(I_OPQ, 4'h3, 64'h3C, 64'hF0, 64'd0, 4'd1);
      step();
      checks++; if ({ve64, zf64, of64} !== {64'hCC, 1'b0, 1'b0}) begin errors++; $display("FAIL xorq got %h/%b/%b want cc/0/0", ve64, zf64, of64); end
      issue(I_OPQ, 4'h4, 64'd5, 64'd5, 64'd0, 4'd1);
      step();
      checks++; if ({ve64, zf64} !== {64'd0, 1'b0}) begin errors++; $display("FAIL opq_bad_fn got %h/%b want 0/0", ve64, zf64); end
      issue(I_HALT, 4'h0, 64'd7, 64'd5, 64'd3, RNONE);
      step();
      checks++; if (ve64 !== 64'd0) begin errors++; $display("FAIL halt got %h want 0", ve64); end
   endtask

   task automatic test_width32();
      issue(I_PUSHQ, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4);
      #1;
      checks++; if ({fv32, fd32} !== {32'hFC, 4'd4}) begin errors++; $display("FAIL push32_fwd got %h/%h want fc/4", fv32, fd32); end
      step();
      checks++; if ({ve32, de32, dm32, ic32, cnd32} !== {32'hFC, 4'd4, RNONE, I_PUSHQ, 1'b1}) begin errors++; $display("FAIL push32 got %h/%h/%h/%h/%b want fc/4/f/a/1", ve32, de32, dm32, ic32, cnd32); end
      issue(I_POPQ, 4'h0, 64'd0, 64'hFC, 64'd0, 4'd4);
      step();
      checks++; if (ve32 !== 32'h100) begin errors++; $display("FAIL pop32 got %h want 100", ve32); end
      issue(I_OPQ, 4'h0, 64'd1, 64'd1, 64'd0, 4'd2);
      step();
      checks++; if ({v32, ve32, va32, zf32, sf32, of32} !== {1'b1, 32'd2, 32'd1, 3'b000}) begin errors++; $display("FAIL add32 got %b/%h/%h/%b%b%b want 1/2/1/000", v32, ve32, va32, zf32, sf32, of32); end
      issue(I_OPQ, 4'h0, 64'd1, 64'd2, 64'd0, 4'd2);
      rst_n = 1'b0;
      step();
      checks++; if ({zf32, v32, ve32} !== {1'b1, 1'b0, 32'd0}) begin errors++; $display("FAIL rst32 got %b/%b/%h want 1/0/0", zf32, v32, ve32); end
      rst_n = 1'b1;
      in_valid = 1'b0;
      step();
      checks++; if ({zf32, v32} !== {1'b1, 1'b0}) begin errors++; $display("FAIL rst32_after got %b/%b want 1/0", zf32, v32); end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_add_ovf();
      test_cond();
      test_cmov();
      test_stall_bubble_exc();
      test_misc_ops();
      test_width32();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter WIDTH, 64, datapath width in bits (legal values 32 and 64).
REQ-002 SHALL have parameter WORD_BYTES, WIDTH/8, stack-pointer step for call/push/ret/pop.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid  in  1, stall  in  1, bubble  in  1, exc_block  in  1, which are the pipeline controls; exc_block means a later stage holds an exception.
REQ-006 SHALL have ports icode  in  4, ifun  in  4, valA/valB/valC  in  WIDTH, dstE/dstM  in  4, carrying the decoded instruction.
REQ-007 SHALL have ports out_valid  out  1, out_icode  out  4, out_valE/out_valA  out  WIDTH, out_dstE/out_dstM  out  4, out_cnd  out  1, which form the registered E-to-M pipeline register.
REQ-008 SHALL have ports zf/sf/of  out  1 (condition-code register), plus fwd_valE  out  WIDTH and fwd_dstE  out  4 (combinational forwarding).

Function
REQ-009 SHALL compute valE: OPq ifun 0..3 = B+A, B-A, B&A, B^A; rrmovq/cmovXX = A; irmovq = C; rmmovq/mrmovq = B+C; call/pushq = B-WORD_BYTES; ret/popq = B+WORD_BYTES; all other icodes = 0.
REQ-010 SHALL wrap all arithmetic modulo 2^WIDTH; OPq with ifun>3 SHALL give valE=0.
REQ-011 SHALL compute flags from the result: zf = (valE==0); sf = valE[WIDTH-1]; of for add = (A,B same sign and result sign differs); of for sub = (A,B signs differ and result sign differs from B); of=0 for and/xor.
REQ-012 SHALL load the CC register on an edge only when in_valid & icode==OPq & ifun<=3 & !stall & !bubble & !exc_block.
REQ-013 SHALL evaluate cnd from the registered CC (pre-update): ifun 0 = 1; 1 le = (sf^of)|zf; 2 l = sf^of; 3 e = zf; 4 ne = !zf; 5 ge = !(sf^of); 6 g = !(sf^of)&!zf; 7..15 = 0.
REQ-014 SHALL force out_dstE=RNONE (0xF) for cmovXX when cnd=0.
REQ-015 SHALL have latency of exactly one cycle: an accepted instruction appears on the out_* ports after the next rising edge.
REQ-016 SHALL drive fwd_valE/fwd_dstE combinationally from the current inputs; fwd_dstE SHALL be RNONE when in_valid=0 or bubble=1.
REQ-017 SHALL hold the output register and the CC on stall; stall SHALL win over bubble.
REQ-018 SHALL load a NOP on bubble, or when in_valid=0 and no stall: out_valid=0, out_icode=NOP (1), out_dstE/out_dstM=RNONE, out_cnd=0, data outputs 0.
REQ-019 SHALL still write the output register when exc_block=1; only the CC update is suppressed.

Reset
REQ-020 SHALL, on an edge with rst_n=0, set zf=1, sf=0, of=0 and load the output register with a NOP (as REQ-018), overriding stall and bubble.
REQ-021 SHALL discard any instruction presented on the reset edge, leaving no side effect.

Structure
REQ-022 SHALL place icode/ifun constants, RNONE, and condition-code enumerations in shared package execute_pkg.
REQ-023 SHALL implement the combinational datapath as sub-module alu (parameter WIDTH; outputs result, zf, sf, of); the CC register, cond logic and pipeline register SHALL reside in execute_pipe.

Verification
REQ-024 SHALL cover, with WIDTH=64: subq A=91 B=100 -> out_valE=9, zf=0 sf=0 of=0 one edge later; addq A=0x7FFFFFFFFFFFFFFF B=1 -> out_valE=0x8000000000000000, sf=1, of=1.
REQ-025 SHALL cover: subq A=3 B=3, then je -> out_cnd=1, then jne -> out_cnd=0, then jle -> out_cnd=1.
REQ-026 SHALL cover: with CC sf=0 of=0 zf=0, cmovl A=9 dstE=3 -> out_valE=9, out_cnd=0, out_dstE=0xF; cmovge -> out_dstE=3.
REQ-027 SHALL cover: stall held 2 cycles during an addq -> outputs and CC unchanged; bubble -> NOP; addq with exc_block=1 -> out_valE correct, CC unchanged.
REQ-028 SHALL cover, with WIDTH=32: pushq valB=0x100 -> out_valE=0xFC; popq valB=0xFC -> 0x100; rst_n=0 mid-stream -> zf=1, out_valid=0 on that edge.
